// File: rtl/spi_dev_mcmd_if.sv
// Byte stream from the SPI protocol wrapper into the command decoder, plus the
// decoded command bus returned to the consumer.
interface spi_dev_mcmd_if #(
    parameter int CMD_LEN = 4
) ();
    logic [7:0]                     pw_wdata;
    logic                           pw_wcmd;
    logic                           pw_wstb;
    logic                           pw_end;
    logic [7:0]                     cmd_op;
    logic [8*CMD_LEN-1:0]           cmd_data;
    logic [$clog2(CMD_LEN+1)-1:0]   cmd_len;
    logic                           cmd_stb;
    logic                           cmd_err;

    modport master (
        output pw_wdata, pw_wcmd, pw_wstb, pw_end,
        input  cmd_op, cmd_data, cmd_len, cmd_stb, cmd_err
    );

    modport slave (
        input  pw_wdata, pw_wcmd, pw_wstb, pw_end,
        output cmd_op, cmd_data, cmd_len, cmd_stb, cmd_err
    );
endinterface

// File: rtl/spi_dev_mcmd.sv
// SPI command decoder: matches a masked opcode family, collects up to CMD_LEN payload
// bytes and reports complete commands (cmd_stb) or too-short ones (cmd_err).
module spi_dev_mcmd #(
    parameter logic [7:0] CMD_BYTE = 8'h00,
    parameter logic [7:0] CMD_MASK = 8'hff,
    parameter int         CMD_LEN  = 4,
    parameter int         MIN_LEN  = CMD_LEN,
    localparam int        DL       = 8*CMD_LEN-1,
    localparam int        DW       = DL+1,
    localparam int        LW       = $clog2(CMD_LEN+1)
) (
    input logic           clk,
    input logic           rst_n,
    spi_dev_mcmd_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PAYLOAD, DRAIN} state_t;

    state_t        state_q;
    logic [7:0]    op_q;
    logic [DL:0]   sh_q, sh_d;
    logic [LW-1:0] cnt_q, cnt_d;
    logic [7:0]    cmd_op_q;
    logic [DL:0]   cmd_data_q;
    logic [LW-1:0] cmd_len_q;
    logic          cmd_stb_q, cmd_err_q;

    logic match_w, data_w, close_w, full_w, long_enough_w;

    assign match_w = bus.pw_wstb & bus.pw_wcmd &
                     (((bus.pw_wdata ^ CMD_BYTE) & CMD_MASK) == 8'h00);
    assign data_w  = bus.pw_wstb & ~bus.pw_wcmd;
    // A new command byte also closes the running transaction.
    assign close_w = bus.pw_end | (bus.pw_wstb & bus.pw_wcmd);

    // Byte is shifted/counted before any same-cycle end is evaluated.
    assign sh_d          = data_w ? ((sh_q << 8) | DW'(bus.pw_wdata)) : sh_q;
    assign cnt_d         = cnt_q + LW'(data_w);
    assign full_w        = data_w && (int'(cnt_d) == CMD_LEN);
    assign long_enough_w = int'(cnt_d) >= MIN_LEN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            op_q       <= '0;
            sh_q       <= '0;
            cnt_q      <= '0;
            cmd_op_q   <= '0;
            cmd_data_q <= '0;
            cmd_len_q  <= '0;
            cmd_stb_q  <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            cmd_stb_q <= 1'b0;
            cmd_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (match_w) begin
                        state_q <= PAYLOAD;
                        op_q    <= bus.pw_wdata;
                        cnt_q   <= '0;
                        sh_q    <= '0;
                    end
                end
                PAYLOAD: begin
                    cnt_q <= cnt_d;
                    sh_q  <= sh_d;
                    if (full_w || (close_w && long_enough_w)) begin
                        cmd_stb_q  <= 1'b1;
                        cmd_op_q   <= op_q;
                        cmd_data_q <= sh_d;
                        cmd_len_q  <= cnt_d;
                    end else if (close_w) begin
                        cmd_err_q <= 1'b1;
                    end
                    if (full_w) begin
                        state_q <= bus.pw_end ? IDLE : DRAIN;
                    end else if (close_w) begin
                        // A matching opcode re-arms straight into a fresh payload.
                        if (match_w) begin
                            op_q  <= bus.pw_wdata;
                            cnt_q <= '0;
                            sh_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DRAIN: begin
                    if (match_w) begin
                        state_q <= PAYLOAD;
                        op_q    <= bus.pw_wdata;
                        cnt_q   <= '0;
                        sh_q    <= '0;
                    end else if (close_w) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_op   = cmd_op_q;
    assign bus.cmd_data = cmd_data_q;
    assign bus.cmd_len  = cmd_len_q;
    assign bus.cmd_stb  = cmd_stb_q;
    assign bus.cmd_err  = cmd_err_q;
endmodule

// File: tb/tb_spi_dev_mcmd.sv
// Bench for spi_dev_mcmd: two instances (A: family 2x, MIN_LEN=2; B: exact 20, MIN_LEN=0)
// share one byte stream; expected command events are queued per instance.
module tb_spi_dev_mcmd;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_dev_mcmd_if #(.CMD_LEN(4)) ifa ();
    spi_dev_mcmd_if #(.CMD_LEN(4)) ifb ();

    spi_dev_mcmd #(.CMD_BYTE(8'h20), .CMD_MASK(8'hF0), .CMD_LEN(4), .MIN_LEN(2))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    spi_dev_mcmd #(.CMD_BYTE(8'h20), .CMD_MASK(8'hFF), .CMD_LEN(4), .MIN_LEN(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    typedef struct packed {
        logic        stb;
        logic        err;
        logic [7:0]  op;
        logic [31:0] data;
        logic [2:0]  len;
    } ev_t;

    ev_t exp_a[$];
    ev_t exp_b[$];
    ev_t got_a, want_a, got_b, want_b;
    int  n_pass  = 0;
    int  n_total = 0;

    function automatic ev_t mkev(input logic e, input logic [7:0] op,
                                 input logic [31:0] d, input logic [2:0] l);
        ev_t v;
        v.stb  = ~e;
        v.err  = e;
        v.op   = op;
        v.data = d;
        v.len  = l;
        return v;
    endfunction

    // Scoreboard: every strobe/err event must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && (ifa.cmd_stb || ifa.cmd_err)) begin
            got_a = '{ifa.cmd_stb, ifa.cmd_err, ifa.cmd_op, ifa.cmd_data, ifa.cmd_len};
            n_total++;
            if (exp_a.size() == 0) begin
                $display("FAIL A_unexpected_event got=%h required=none", got_a);
            end else begin
                want_a = exp_a.pop_front();
                if (got_a !== want_a) $display("FAIL A_event got=%h required=%h", got_a, want_a);
                else n_pass++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && (ifb.cmd_stb || ifb.cmd_err)) begin
            got_b = '{ifb.cmd_stb, ifb.cmd_err, ifb.cmd_op, ifb.cmd_data, ifb.cmd_len};
            n_total++;
            if (exp_b.size() == 0) begin
                $display("FAIL B_unexpected_event got=%h required=none", got_b);
            end else begin
                want_b = exp_b.pop_front();
                if (got_b !== want_b) $display("FAIL B_event got=%h required=%h", got_b, want_b);
                else n_pass++;
            end
        end
    end

    task automatic put(input logic c, input logic s, input logic e, input logic [7:0] d);
        @(negedge clk);
        ifa.pw_wcmd = c; ifa.pw_wstb = s; ifa.pw_end = e; ifa.pw_wdata = d;
        ifb.pw_wcmd = c; ifb.pw_wstb = s; ifb.pw_end = e; ifb.pw_wdata = d;
    endtask

    task automatic wcmd(input logic [7:0] d); put(1'b1, 1'b1, 1'b0, d); endtask
    task automatic byt(input logic [7:0] d);  put(1'b0, 1'b1, 1'b0, d); endtask
    task automatic pend();                    put(1'b0, 1'b0, 1'b1, 8'h00); endtask

    task automatic settle();
        put(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        put(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if ({ifa.cmd_stb, ifa.cmd_err, ifa.cmd_op, ifa.cmd_data, ifa.cmd_len} !== '0)
            $display("FAIL reset_A got op=%h data=%h len=%0d required 0", ifa.cmd_op, ifa.cmd_data, ifa.cmd_len);
        else n_pass++;
        n_total++;
        if ({ifb.cmd_stb, ifb.cmd_err, ifb.cmd_op, ifb.cmd_data, ifb.cmd_len} !== '0)
            $display("FAIL reset_B got op=%h data=%h len=%0d required 0", ifb.cmd_op, ifb.cmd_data, ifb.cmd_len);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_cmd();
        exp_a.push_back(mkev(1'b0, 8'h20, 32'h11223344, 3'd4));
        exp_b.push_back(mkev(1'b0, 8'h20, 32'h11223344, 3'd4));
        wcmd(8'h20); byt(8'h11); byt(8'h22); byt(8'h33); byt(8'h44);
        @(posedge clk); #1;
        n_total++;
        if (ifa.cmd_stb !== 1'b1 || ifb.cmd_stb !== 1'b1)
            $display("FAIL full_latency got stb_a=%b stb_b=%b required 1", ifa.cmd_stb, ifb.cmd_stb);
        else n_pass++;
        pend();
        settle();
        n_total++;
        if (exp_a.size() != 0 || exp_b.size() != 0)
            $display("FAIL full_pending got a=%0d b=%0d required 0", exp_a.size(), exp_b.size());
        else n_pass++;
    endtask

    task automatic test_min_len();
        exp_a.push_back(mkev(1'b0, 8'h20, 32'h0000AABB, 3'd2));
        exp_b.push_back(mkev(1'b0, 8'h20, 32'h0000AABB, 3'd2));
        wcmd(8'h20); byt(8'hAA); byt(8'hBB); pend();
        // Short for A: err with outputs retained; B accepts a single byte.
        exp_a.push_back(mkev(1'b1, 8'h20, 32'h0000AABB, 3'd2));
        exp_b.push_back(mkev(1'b0, 8'h20, 32'h000000AA, 3'd1));
        wcmd(8'h20); byt(8'hAA); pend();
        settle();
        n_total++;
        if (exp_a.size() != 0 || exp_b.size() != 0)
            $display("FAIL min_len_pending got a=%0d b=%0d required 0", exp_a.size(), exp_b.size());
        else n_pass++;
    endtask

    task automatic test_mask();
        exp_a.push_back(mkev(1'b0, 8'h2C, 32'h01020304, 3'd4));
        wcmd(8'h2C); byt(8'h01); byt(8'h02); byt(8'h03); byt(8'h04); pend();
        wcmd(8'h3C); byt(8'h05); byt(8'h06); byt(8'h07); byt(8'h08); pend();
        settle();
        n_total++;
        if (exp_a.size() != 0 || exp_b.size() != 0)
            $display("FAIL mask_pending got a=%0d b=%0d required 0", exp_a.size(), exp_b.size());
        else n_pass++;
        n_total++;
        if (ifa.cmd_op !== 8'h2C || ifb.cmd_op !== 8'h20)
            $display("FAIL mask_op got a=%h b=%h required a=2c b=20", ifa.cmd_op, ifb.cmd_op);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        exp_a.push_back(mkev(1'b0, 8'h20, 32'h01020304, 3'd4));
        exp_b.push_back(mkev(1'b0, 8'h20, 32'h01020304, 3'd4));
        wcmd(8'h20);
        for (int i = 1; i <= 6; i++) byt(8'(i));
        pend();
        exp_a.push_back(mkev(1'b0, 8'h20, 32'h0000A1A2, 3'd2));
        exp_b.push_back(mkev(1'b0, 8'h20, 32'h0000A1A2, 3'd2));
        exp_a.push_back(mkev(1'b0, 8'h20, 32'hB1B2B3B4, 3'd4));
        exp_b.push_back(mkev(1'b0, 8'h20, 32'hB1B2B3B4, 3'd4));
        wcmd(8'h20); byt(8'hA1); byt(8'hA2);
        wcmd(8'h20); byt(8'hB1); byt(8'hB2); byt(8'hB3); byt(8'hB4); pend();
        settle();
        n_total++;
        if (exp_a.size() != 0 || exp_b.size() != 0)
            $display("FAIL b2b_pending got a=%0d b=%0d required 0", exp_a.size(), exp_b.size());
        else n_pass++;
    endtask

    task automatic test_same_cycle_end();
        exp_a.push_back(mkev(1'b0, 8'h20, 32'h00C1C2C3, 3'd3));
        exp_b.push_back(mkev(1'b0, 8'h20, 32'h00C1C2C3, 3'd3));
        wcmd(8'h20); byt(8'hC1); byt(8'hC2);
        put(1'b0, 1'b1, 1'b1, 8'hC3);
        settle();
        n_total++;
        if (exp_a.size() != 0 || exp_b.size() != 0)
            $display("FAIL same_cycle_pending got a=%0d b=%0d required 0", exp_a.size(), exp_b.size());
        else n_pass++;
    endtask

    task automatic test_short_and_zero();
        // Opcode then end: A too short, B delivers an empty command.
        exp_a.push_back(mkev(1'b1, 8'h20, 32'h00C1C2C3, 3'd3));
        exp_b.push_back(mkev(1'b0, 8'h20, 32'h00000000, 3'd0));
        wcmd(8'h20); pend();
        // Non-matching opcode closes the open command; following bytes are ignored.
        exp_a.push_back(mkev(1'b1, 8'h20, 32'h00C1C2C3, 3'd3));
        exp_b.push_back(mkev(1'b0, 8'h20, 32'h000000D1, 3'd1));
        wcmd(8'h20); byt(8'hD1); wcmd(8'h3C); byt(8'hE1); byt(8'hE2); pend();
        byt(8'hF1); byt(8'hF2);
        settle();
        n_total++;
        if (exp_a.size() != 0 || exp_b.size() != 0)
            $display("FAIL short_pending got a=%0d b=%0d required 0", exp_a.size(), exp_b.size());
        else n_pass++;
        n_total++;
        if (ifa.cmd_data !== 32'h00C1C2C3 || ifa.cmd_len !== 3'd3)
            $display("FAIL err_retain got data=%h len=%0d required 00c1c2c3/3", ifa.cmd_data, ifa.cmd_len);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        wcmd(8'h20); byt(8'h11); byt(8'h22);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({ifa.cmd_stb, ifa.cmd_err, ifa.cmd_op, ifa.cmd_data, ifa.cmd_len} !== '0 ||
            {ifb.cmd_stb, ifb.cmd_err, ifb.cmd_op, ifb.cmd_data, ifb.cmd_len} !== '0)
            $display("FAIL reset_mid got a_data=%h b_data=%h required 0", ifa.cmd_data, ifb.cmd_data);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_a.push_back(mkev(1'b0, 8'h20, 32'h55667788, 3'd4));
        exp_b.push_back(mkev(1'b0, 8'h20, 32'h55667788, 3'd4));
        byt(8'h33);
        wcmd(8'h20); byt(8'h55); byt(8'h66); byt(8'h77); byt(8'h88); pend();
        settle();
        n_total++;
        if (exp_a.size() != 0 || exp_b.size() != 0)
            $display("FAIL reset_mid_pending got a=%0d b=%0d required 0", exp_a.size(), exp_b.size());
        else n_pass++;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        ifa.pw_wdata = 8'h00; ifa.pw_wcmd = 1'b0; ifa.pw_wstb = 1'b0; ifa.pw_end = 1'b0;
        ifb.pw_wdata = 8'h00; ifb.pw_wcmd = 1'b0; ifb.pw_wstb = 1'b0; ifb.pw_end = 1'b0;
        test_reset();
        test_full_cmd();
        test_min_len();
        test_mask();
        test_back_to_back();
        test_same_cycle_end();
        test_short_and_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
